// File: rtl/apb_reg_bridge_pkg.sv
// Shared definitions for the APB register-file bridge and future APB slaves:
// default register window, FSM state encoding and APB response codes.
package apb_reg_bridge_pkg;

  localparam logic [15:0] REG_BASE_ADDR = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_addr_check.sv
// Combinational address check: flags accesses outside the 16-byte register
// window at BASE_ADDR or not aligned to a 32-bit word.
module apb_addr_check #(
  parameter int unsigned        AW        = 16,
  parameter logic [AW-1:0]      BASE_ADDR = 16'h0100
) (
  input  logic [AW-1:0] addr,
  output logic          err
);

  // Bits [3:2] select the word inside the window and take no part in the check.
  localparam logic [AW-1:0] WIN_MASK   = ~(AW'(4'hC));
  localparam logic [AW-1:0] WIN_EXPECT = BASE_ADDR & ~(AW'(4'hF));

  always_comb begin
    err = ((addr & WIN_MASK) != WIN_EXPECT);
  end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the peripheral register file: converts APB transfers
// into a one-cycle write strobe, registers read data, adds wait states and errors.
module apb_reg_bridge
  import apb_reg_bridge_pkg::*;
#(
  parameter int unsigned   DW          = 32,
  parameter int unsigned   AW          = 16,
  parameter logic [AW-1:0] BASE_ADDR   = AW'(REG_BASE_ADDR),
  parameter int unsigned   WAIT_CYCLES = 0,
  parameter int unsigned   ECW         = 8
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [AW-1:0]  PADDR,
  input  logic [DW-1:0]  PWDATA,
  output logic [DW-1:0]  PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic           W_ENABLE,
  output logic [AW-1:0]  ADDR,
  output logic [DW-1:0]  WDATA,
  input  logic [DW-1:0]  RDATA,
  output logic [ECW-1:0] ERR_CNT
);

  state_t     state;
  logic [3:0] cnt;
  logic       wr_q;
  logic       err_q;
  logic       addr_err;

  apb_addr_check #(
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_check (
    .addr (PADDR),
    .err  (addr_err)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      PRDATA   <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      W_ENABLE <= 1'b0;
      ADDR     <= '0;
      WDATA    <= '0;
      ERR_CNT  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            ADDR  <= PADDR;
            WDATA <= PWDATA;
            wr_q  <= PWRITE;
            err_q <= addr_err;
            cnt   <= 4'(WAIT_CYCLES);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (PENABLE) begin
            state    <= ST_DONE;
            PREADY   <= 1'b1;
            PSLVERR  <= err_q ? RESP_ERROR : RESP_OKAY;
            W_ENABLE <= wr_q & ~err_q;
            PRDATA   <= (!wr_q && !err_q) ? RDATA : '0;
          end
        end
        ST_DONE: begin
          PREADY   <= 1'b0;
          PSLVERR  <= 1'b0;
          W_ENABLE <= 1'b0;
          if (err_q && (ERR_CNT != '1)) begin
            ERR_CNT <= ERR_CNT + 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Randomized scoreboard bench for apb_reg_bridge with a word-array reference
// model of the register file and a saturating error tally.
module tb_apb_reg_bridge;

  localparam int unsigned W = 2;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        W_ENABLE;
  logic [15:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic [7:0]  ERR_CNT;

  apb_reg_bridge #(
    .DW          (32),
    .AW          (16),
    .BASE_ADDR   (16'h0100),
    .WAIT_CYCLES (W),
    .ECW         (8)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .W_ENABLE (W_ENABLE),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .RDATA    (RDATA),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 PCLK = ~PCLK;

  // Register file seen by the DUT; cleared by reset so the model can track it.
  logic [31:0] rf [4];
  always @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (W_ENABLE) begin
      rf[ADDR[3:2]] <= WDATA;
    end
  end
  assign RDATA = rf[ADDR[3:2]];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model
  typedef struct {
    logic        wr;
    logic        err;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [7:0]  cnt_after;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] refmem [4];
  int          model_errs;

  function automatic bit bad_addr(input logic [15:0] a);
    return (a < 16'h0100) || (a > 16'h010F) || ((a % 4) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) refmem[i] = '0;
    model_errs = 0;
  endtask

  // Monitor: pops an expectation whenever the DUT completes a transfer.
  bit         cnt_pending = 0;
  logic [7:0] cnt_exp;
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESET) begin
      if (cnt_pending) begin
        check("err_cnt", {24'h0, ERR_CNT}, {24'h0, cnt_exp});
        cnt_pending = 0;
      end
      if (PREADY) begin
        if (sbq.size() == 0) begin
          check("unexpected_pready", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("pslverr", {31'h0, PSLVERR}, {31'h0, e.err});
          check("prdata", PRDATA, e.prdata);
          check("w_enable", {31'h0, W_ENABLE}, {31'h0, e.wr & ~e.err});
          if (e.wr && !e.err) begin
            check("strobe_addr", {16'h0, ADDR}, {16'h0, e.addr});
            check("strobe_wdata", WDATA, e.wdata);
          end
          cnt_exp     = e.cnt_after;
          cnt_pending = 1;
        end
      end else if (W_ENABLE) begin
        check("stray_strobe", 32'd1, 32'd0);
      end
    end
  end

  bit b2b_mode   = 0;
  bit have_prev  = 0;
  int last_setup = 0;

  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    bit   seen;
    int   idx;
    e.wr    = wr;
    e.err   = bad_addr(addr);
    e.addr  = addr;
    e.wdata = data;
    idx     = (int'(addr) - 32'h100) / 4;
    e.prdata = (!wr && !e.err) ? refmem[idx] : 32'h0;
    if (wr && !e.err) refmem[idx] = data;
    if (e.err) model_errs++;
    e.cnt_after = (model_errs > 255) ? 8'hFF : 8'(model_errs);
    sbq.push_back(e);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    if (b2b_mode && have_prev) check("spacing", 32'(cyc - last_setup), 32'(3 + W));
    have_prev  = 1;
    last_setup = cyc;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      if (PREADY) seen = 1;
    end
    check("latency", seen ? 32'(cyc - last_setup) : 32'd999, 32'(2 + W));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"}, PRDATA, 32'h0);
    check({tag, "_ctrl"}, {29'h0, PREADY, PSLVERR, W_ENABLE}, 32'h0);
    check({tag, "_addr"}, {16'h0, ADDR}, 32'h0);
    check({tag, "_wdata"}, WDATA, 32'h0);
    check({tag, "_errcnt"}, {24'h0, ERR_CNT}, 32'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 16'h0100 + 16'(4 * $urandom_range(0, 3));
      2:       return 16'h0100 + 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n_rdy;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check_all_zero("reset");
    @(posedge PCLK); #1;

    // Directed write, read-back, two error writes
    xfer(1'b1, 16'h0104, 32'hDEADBEEF);
    xfer(1'b0, 16'h0104, 32'h0);
    xfer(1'b1, 16'h0200, 32'h11111111);
    xfer(1'b1, 16'h0102, 32'h22222222);
    @(negedge PCLK);
    check("err_cnt_two", {24'h0, ERR_CNT}, 32'd2);
    @(posedge PCLK); #1;

    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge PCLK);
        #1;
      end
    end

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      xfer(1'($urandom_range(0, 1)), (i % 2 == 0) ? 16'h0300 : 16'h0101, $urandom);
    end
    @(negedge PCLK);
    check("err_cnt_sat", {24'h0, ERR_CNT}, 32'hFF);
    @(posedge PCLK); #1;

    // Reset during WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0108; PWDATA = 32'hCAFEF00D;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    @(negedge PCLK);
    check_all_zero("midreset");
    repeat (4) @(posedge PCLK);
    #1;
    xfer(1'b1, 16'h0108, 32'h0BADC0DE);
    xfer(1'b0, 16'h0108, 32'h0);

    // Master abort during WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0100; PWDATA = 32'h55555555;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    n_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (PREADY) n_rdy++;
    end
    check("abort_no_pready", 32'(n_rdy), 32'd0);
    @(posedge PCLK); #1;

    // Back-to-back writes, then read both back
    b2b_mode  = 1;
    have_prev = 0;
    xfer(1'b1, 16'h0100, 32'h12345678);
    xfer(1'b1, 16'h010C, 32'h9ABCDEF0);
    xfer(1'b0, 16'h0100, 32'h0);
    xfer(1'b0, 16'h010C, 32'h0);
    b2b_mode = 0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
